// File: rtl/besdpb.sv
// Byte-enabled single-address block RAM with write-first read behaviour.
// Synchronous write and read on one shared address; the registered read
// output has an asynchronous clear.
module besdpb #(
  parameter int ADDRESS_BITWIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [31:0]                 data_in,
  output logic [31:0]                 data_out
);

  localparam int DEPTH = 1 << ADDRESS_BITWIDTH;

  logic [31:0] mem [DEPTH];
  logic [31:0] data_out_d;
  logic [31:0] data_out_q;

  // Write-first: enabled bytes forward the incoming data, other bytes show
  // the stored word.
  always_comb begin
    // NOTE: assign a default first so no path leaves data_out_d unassigned (latch).
    data_out_d = mem[address];
    for (int i = 0; i < 4; i++) begin
      if (write_enable[i]) begin
        data_out_d[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // NOTE: the array has no reset, which lets it map onto block RAM; rst_n only gates writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (write_enable[i]) begin
          mem[address][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_besdpb.sv
// Directed self-checking bench for besdpb with hand-computed expectations.
module tb_besdpb;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    write_enable;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;

  int tests_run = 0;
  int tests_failed = 0;

  besdpb #(.ADDRESS_BITWIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one set of inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic [3:0] we, input logic [AW-1:0] addr, input logic [31:0] din);
    write_enable = we;
    address      = addr;
    data_in      = din;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lat_data [3];
  logic [AW-1:0] lat_addr [3];

  initial begin
    rst_n        = 1'b1;
    write_enable = 4'b0000;
    address      = '0;
    data_in      = '0;
    #1 rst_n = 1'b0;
    #1 check("reset_out", data_out, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_held", data_out, 32'h0);
    #2 rst_n = 1'b1;

    // Full-word write then read at 5, 0 and the top address
    cyc(4'b1111, 16'd5, 32'hDEADBEEF);
    check("wr_thru_5", data_out, 32'hDEADBEEF);
    cyc(4'b1111, 16'd0, 32'h01234567);
    cyc(4'b1111, 16'hFFFF, 32'hCAFEF00D);
    cyc(4'b0000, 16'd5, 32'h0);
    check("rd_5", data_out, 32'hDEADBEEF);
    cyc(4'b0000, 16'd0, 32'h0);
    check("rd_0", data_out, 32'h01234567);
    cyc(4'b0000, 16'hFFFF, 32'h0);
    check("rd_max", data_out, 32'hCAFEF00D);
    cyc(4'b0000, 16'hFFFF, 32'h0);
    check("hold", data_out, 32'hCAFEF00D);

    // Byte enables
    cyc(4'b1111, 16'd3, 32'h11223344);
    cyc(4'b0101, 16'd3, 32'hAABBCCDD);
    check("be_thru", data_out, 32'h11BB33DD);
    cyc(4'b0000, 16'd3, 32'h0);
    check("be_rd", data_out, 32'h11BB33DD);
    cyc(4'b0000, 16'd3, 32'hFFFFFFFF);
    check("be_none", data_out, 32'h11BB33DD);
    cyc(4'b0000, 16'd3, 32'h0);
    check("be_none_rd", data_out, 32'h11BB33DD);

    // Write-through with partial enables
    cyc(4'b1111, 16'd7, 32'h0);
    cyc(4'b0011, 16'd7, 32'h12345678);
    check("wt_partial", data_out, 32'h00005678);
    cyc(4'b0000, 16'd7, 32'h0);
    check("wt_rd", data_out, 32'h00005678);

    // Latency: alternate addresses 1,2,1; output changes only at the edge
    cyc(4'b1111, 16'd1, 32'hA);
    cyc(4'b1111, 16'd2, 32'hB);
    lat_addr[0] = 16'd1; lat_data[0] = 32'hA;
    lat_addr[1] = 16'd2; lat_data[1] = 32'hB;
    lat_addr[2] = 16'd1; lat_data[2] = 32'hA;
    for (int i = 0; i < 3; i++) begin
      write_enable = 4'b0000;
      address      = lat_addr[i];
      #2 check($sformatf("lat_pre%0d", i), data_out, (i == 0) ? 32'hB : lat_data[i-1]);
      @(posedge clk);
      #1 check($sformatf("lat_post%0d", i), data_out, lat_data[i]);
    end

    // Asynchronous reset mid-cycle, writes ignored during reset
    cyc(4'b0000, 16'd5, 32'h0);
    check("pre_rst", data_out, 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1 check("async_clr", data_out, 32'h0);
    write_enable = 4'b1111;
    address      = 16'd5;
    data_in      = 32'h5555AAAA;
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_out_0", data_out, 32'h0);
    rst_n = 1'b1;
    cyc(4'b0000, 16'd5, 32'h0);
    check("rst_mem_kept", data_out, 32'hDEADBEEF);
    cyc(4'b0000, 16'd3, 32'h0);
    check("rst_mem_kept3", data_out, 32'h11BB33DD);

    // First edge after release performs a normal write
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(4'b1111, 16'd9, 32'h0BADF00D);
    check("post_rel_wr", data_out, 32'h0BADF00D);
    cyc(4'b0000, 16'd9, 32'h0);
    check("post_rel_rd", data_out, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
